pipe_elastic_stage: RTL

Parametrised elastic pipeline register that replaces the fixed stall/flush pipeline registers between core stages (IF/ID, ID/EX, EX/MEM, MEM/WB). It holds up to DEPTH payload entries in order, with a valid/ready handshake on both sides, a synchronous flush, and a hold input for legacy global stall. It also reports occupancy, so stages can decouple instead of stalling in lock-step.

---
 rtl/core_pipe_pkg.sv | 10 +
 rtl/pipe_elastic_stage.sv | 51 +++++
 2 files changed

// File: rtl/core_pipe_pkg.sv
// core_pipe_pkg: shared constants and pointer/count helpers for elastic pipeline stages
package core_pipe_pkg;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/pipe_elastic_stage.sv
// pipe_elastic_stage: DEPTH-entry in-order elastic register with flush, hold and occupancy
module pipe_elastic_stage
  import core_pipe_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  parameter logic [WIDTH-1:0] RST_VALUE = WIDTH'(NOP_INSTR)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         hold,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic [cnt_width(DEPTH)-1:0]  count
);
  localparam int CW = cnt_width(DEPTH);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic push, pop;
  // ready depends only on registered occupancy, never on the downstream side
  assign in_ready = cnt != CW'(DEPTH);
  assign out_valid = cnt != '0;
  assign push = in_valid & in_ready & ~flush;
  assign pop = out_valid & out_ready & ~hold & ~flush;
  assign out_data = out_valid ? mem[rp] : RST_VALUE;
  assign count = cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      wp <= '0;
      rp <= '0;
    end else if (flush) begin
      cnt <= '0;
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= PW'(ptr_inc(32'(wp), DEPTH));
      if (pop) rp <= PW'(ptr_inc(32'(rp), DEPTH));
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  // storage is flops without reset; contents are hidden whenever the buffer is empty
  always_ff @(posedge clk)
    if (push) mem[wp] <= in_data;
endmodule
